// File: rtl/cv32e40s_pkg.sv
// ============================================================================
//  Module      : cv32e40s_pkg
//  Description : Shared types and integrity helpers for the instruction OBI
//                port. The responder and the core-side checker both use
//                calc_instr_achk and calc_rchk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40s_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_ACHK_W = 12;
    localparam int OBI_RCHK_W = 5;

    // One granted transfer waiting for its memory read
    typedef struct packed {
        logic [31:2] addr;
        logic        achk_err;
    } obi_resp_fifo_entry_t;

    // Every A-channel field that must stay stable while a request waits
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [1:0]  memtype;
        logic        dbg;
        logic [11:0] achk;
    } obi_instr_achan_t;

    // Instruction fetches never write: wdata=0, atop=0, be=4'hF, we=0 are fixed
    function automatic logic [11:0] calc_instr_achk(
        input logic [31:0] addr,
        input logic [2:0]  prot,
        input logic [1:0]  memtype,
        input logic        dbg
    );
        logic [31:0] a;
        logic [11:0] achk;
        a          = addr & 32'hFFFF_FFFC;
        achk       = '0;
        achk[6]    = ~dbg;
        achk[5]    = ~^{4'hF, 1'b0};
        achk[4]    = ~^{prot, memtype};
        achk[3]    = ^a[31:24];
        achk[2]    = ^a[23:16];
        achk[1]    = ^a[15:8];
        achk[0]    = ^a[7:0];
        return achk;
    endfunction

    // exokay is always 0 on this port
    function automatic logic [4:0] calc_rchk(
        input logic [31:0] rdata,
        input logic        err
    );
        return {^{err, 1'b0}, ^rdata[31:24], ^rdata[23:16], ^rdata[15:8], ^rdata[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40s_instr_obi_responder_if.sv
// ============================================================================
//  Module      : cv32e40s_instr_obi_responder_if
//  Description : Instruction OBI A/R channel bundle with Xsecure integrity.
//                master: core side (drives req/A fields)
//                slave : responder side (drives gnt and the R channel)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40s_instr_obi_responder_if;
    import cv32e40s_pkg::*;

    logic                  req;
    logic                  reqpar;
    logic [OBI_ADDR_W-1:0] addr;
    logic [2:0]            prot;
    logic [1:0]            memtype;
    logic                  dbg;
    logic [OBI_ACHK_W-1:0] achk;
    logic                  gnt;
    logic                  gntpar;
    logic                  rvalid;
    logic                  rvalidpar;
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
    logic [OBI_RCHK_W-1:0] rchk;

    modport master (
        output req, reqpar, addr, prot, memtype, dbg, achk,
        input  gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
    );

    modport slave (
        input  req, reqpar, addr, prot, memtype, dbg, achk,
        output gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
    );
endinterface

`default_nettype wire

// File: rtl/cv32e40s_obi_resp_fifo.sv
// ============================================================================
//  Module      : cv32e40s_obi_resp_fifo
//  Description : Parameterised synchronous FIFO (DEPTH >= 1).
//                Ports: push_i/din_i, pop_i/dout_o (head, show-ahead),
//                full_o, empty_o, count_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_obi_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 31
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           push_i,
    input  wire logic [WIDTH-1:0]               din_i,
    input  wire logic                           pop_i,
    output logic      [WIDTH-1:0]               dout_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic      [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

`default_nettype wire

// File: rtl/cv32e40s_instr_obi_responder.sv
// ============================================================================
//  Module      : cv32e40s_instr_obi_responder
//  Description : Slave end of the instruction OBI port with Xsecure integrity.
//                Checks reqpar/achk, grants into an in-order FIFO, reads a
//                synchronous memory and returns rdata/err with rvalidpar/rchk.
//  Ports       : clk, rst (sync, active-high); obi (slave modport, A+R ch);
//                gnt_stall_i, resp_stall_i (back-pressure); mem_re_o,
//                mem_addr_o, mem_rdata_i, mem_err_i (memory, 1-cycle read);
//                protocol_err_o (sticky violation flag).
//  Option      : CV32E40S_OBI_RESP_FAULT_INJ_EN adds fault_i[2:0] which
//                inverts gntpar_o / rvalidpar_o / rchk_o[0] (during rvalid).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_instr_obi_responder
    import cv32e40s_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit ERR_ON_ACHK     = 1'b1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    cv32e40s_instr_obi_responder_if.slave obi,
    input  wire logic                 gnt_stall_i,
    input  wire logic                 resp_stall_i,
    output logic                      mem_re_o,
    output logic [29:0]               mem_addr_o,
    input  wire logic [31:0]          mem_rdata_i,
    input  wire logic                 mem_err_i,
    output logic                      protocol_err_o
`ifdef CV32E40S_OBI_RESP_FAULT_INJ_EN
    ,
    input  wire logic [2:0]           fault_i
`endif
);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENTRY_W = $bits(obi_resp_fifo_entry_t);

    obi_resp_fifo_entry_t push_entry, head;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 gnt, mem_re, achk_mismatch, violation;
    obi_instr_achan_t     achan;
    logic [31:0]          rdata;
    logic                 err;
    logic [4:0]           rchk;
    logic [2:0]           fault;

    // Stage-2 and protocol-tracking state
    logic                 rvalid_q, rvalid_d;
    logic                 kill_q, kill_d;
    logic                 hold_q, hold_d;
    obi_instr_achan_t     achan_q, achan_d;
    logic                 perr_q, perr_d;

`ifdef CV32E40S_OBI_RESP_FAULT_INJ_EN
    assign fault = fault_i;
`else
    assign fault = 3'b000;
`endif

    assign achan         = '{addr: obi.addr, prot: obi.prot, memtype: obi.memtype,
                             dbg: obi.dbg, achk: obi.achk};
    assign achk_mismatch = obi.req &&
                           (calc_instr_achk(obi.addr, obi.prot, obi.memtype, obi.dbg) != obi.achk);

    // The grant ignores a same-cycle pop, so a full FIFO never grants
    assign gnt        = !rst && obi.req && !gnt_stall_i && !fifo_full &&
                        (fifo_count < CNT_W'(MAX_OUTSTANDING));
    assign push_entry = '{addr: obi.addr[31:2], achk_err: achk_mismatch};

    assign head       = obi_resp_fifo_entry_t'(fifo_dout);
    assign mem_re     = !rst && !fifo_empty && !resp_stall_i;
    assign mem_re_o   = mem_re;
    assign mem_addr_o = head.addr;

    cv32e40s_obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (gnt),
        .din_i   (push_entry),
        .pop_i   (mem_re),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rvalid_d  = mem_re;
        kill_d    = head.achk_err && ERR_ON_ACHK;
        hold_d    = obi.req && !gnt;
        achan_d   = achan;
        // A waiting request must keep req high and every A field stable
        violation = (obi.reqpar == obi.req) || achk_mismatch ||
                    (hold_q && (!obi.req || (achan != achan_q)));
        perr_d    = perr_q || violation;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            kill_q   <= 1'b0;
            hold_q   <= 1'b0;
            achan_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            kill_q   <= kill_d;
            hold_q   <= hold_d;
            achan_q  <= achan_d;
            perr_q   <= perr_d;
        end
    end

    // Memory data arrives combinationally in stage 2; a bad-achk transfer returns zero data
    assign rdata = (rvalid_q && !kill_q) ? mem_rdata_i : 32'h0;
    assign err   = rvalid_q && (mem_err_i || kill_q);
    assign rchk  = rvalid_q ? calc_rchk(rdata, err) : 5'b0;

    assign obi.gnt       = gnt;
    assign obi.gntpar    = !gnt ^ fault[0];
    assign obi.rvalid    = rvalid_q;
    assign obi.rvalidpar = !rvalid_q ^ fault[1];
    assign obi.rdata     = rdata;
    assign obi.err       = err;
    assign obi.rchk      = rchk ^ {4'b0, fault[2] && rvalid_q};
    assign protocol_err_o = perr_q;
endmodule

`default_nettype wire
